// File: rtl/register_file_if.sv
// -----------------------------------------------------------------------------
// register_file_if
//   Bundles the write port, the three read ports and the PC load path of the
//   ARM general register file so decode/writeback logic and the register file
//   share a single connection.
//
//   Signals (directions seen from the register file, i.e. the slave side):
//     LE     in   write enable for the general write port
//     RW     in   write register select (4-bit)
//     PW     in   write data
//     RA     in   read select, port A
//     RB     in   read select, port B
//     RD     in   read select, port D (store data)
//     PA     out  read data, port A
//     PB     out  read data, port B
//     PD     out  read data, port D
//     PC_LE  in   load enable for R15 via the PC path
//     PC_in  in   next PC value
//     PC_out out  current R15 contents
//
//   Modports:
//     master  - decode/writeback side, drives selects, data and enables
//     slave   - register file side, drives read data and PC_out
// -----------------------------------------------------------------------------
interface register_file_if #(
    parameter int WIDTH = 32
) ();

    logic             LE;
    logic [3:0]       RW;
    logic [WIDTH-1:0] PW;
    logic [3:0]       RA;
    logic [3:0]       RB;
    logic [3:0]       RD;
    logic [WIDTH-1:0] PA;
    logic [WIDTH-1:0] PB;
    logic [WIDTH-1:0] PD;
    logic             PC_LE;
    logic [WIDTH-1:0] PC_in;
    logic [WIDTH-1:0] PC_out;

    modport master (
        output LE,
        output RW,
        output PW,
        output RA,
        output RB,
        output RD,
        output PC_LE,
        output PC_in,
        input  PA,
        input  PB,
        input  PD,
        input  PC_out
    );

    modport slave (
        input  LE,
        input  RW,
        input  PW,
        input  RA,
        input  RB,
        input  RD,
        input  PC_LE,
        input  PC_in,
        output PA,
        output PB,
        output PD,
        output PC_out
    );

endinterface : register_file_if

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   16 x WIDTH ARM general register file: R0-R14 plus R15 as program counter.
//   One decoded write port, three combinational read ports built from 16:1
//   multiplexers, and a dedicated PC load path into R15.
//
//   Parameters:
//     WIDTH     data width of every register and data port
//     RESET_PC  value loaded into R15 on reset
//     BYPASS    1 = a same-cycle general write is forwarded to matching read
//               ports; 0 = read ports show registered contents only
//
//   Ports:
//     clk    in   system clock, rising-edge active
//     reset  in   synchronous reset, active-high
//     bus    slave modport of register_file_if (write port, read ports,
//                 PC load path and PC_out)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// register_file_mux16
//   16:1 read multiplexer with a 4-bit select. An unknown select yields an
//   unknown output so that X on one read port does not leak into the others.
//
//   Ports:
//     sel_i   in   4-bit select
//     din_i   in   16 packed WIDTH-bit inputs, index = select value
//     dout_o  out  selected input
// -----------------------------------------------------------------------------
module register_file_mux16 #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]             sel_i,
    input  logic [15:0][WIDTH-1:0] din_i,
    output logic [WIDTH-1:0]       dout_o
);

    // Select one of sixteen registered values.
    always_comb begin
        dout_o = {WIDTH{1'bx}};
        case (sel_i)
            4'd0:    dout_o = din_i[0];
            4'd1:    dout_o = din_i[1];
            4'd2:    dout_o = din_i[2];
            4'd3:    dout_o = din_i[3];
            4'd4:    dout_o = din_i[4];
            4'd5:    dout_o = din_i[5];
            4'd6:    dout_o = din_i[6];
            4'd7:    dout_o = din_i[7];
            4'd8:    dout_o = din_i[8];
            4'd9:    dout_o = din_i[9];
            4'd10:   dout_o = din_i[10];
            4'd11:   dout_o = din_i[11];
            4'd12:   dout_o = din_i[12];
            4'd13:   dout_o = din_i[13];
            4'd14:   dout_o = din_i[14];
            4'd15:   dout_o = din_i[15];
            default: dout_o = {WIDTH{1'bx}};
        endcase
    end

endmodule : register_file_mux16

module register_file #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int               BYPASS   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    register_file_if.slave        bus
);

    localparam int  NUM_REGS  = 16;
    localparam int  PC_IDX    = 15;
    localparam int  NUM_PORTS = 3;
    localparam bit  BYPASS_ON = (BYPASS != 0);

    // Binary-to-one-hot write decoder.
    function automatic logic [NUM_REGS-1:0] decode_4to16(input logic [3:0] sel);
        logic [NUM_REGS-1:0] onehot;
        onehot      = 16'h0000;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

    logic [NUM_REGS-1:0][WIDTH-1:0]  regs_q;
    logic [NUM_REGS-1:0][WIDTH-1:0]  regs_d;
    logic [NUM_REGS-1:0]             wr_en_s;
    logic                            fwd_en_s;
    logic [NUM_PORTS-1:0][3:0]       rd_sel_s;
    logic [NUM_PORTS-1:0][WIDTH-1:0] rd_mux_s;
    logic [NUM_PORTS-1:0][WIDTH-1:0] rd_data_s;

    // One-hot write enable, all zero when the write port is idle.
    always_comb begin
        if (bus.LE) begin
            wr_en_s = decode_4to16(bus.RW);
        end else begin
            wr_en_s = 16'h0000;
        end
    end

    // Next-state for every register; R15 arbitrates the general write over
    // the PC load so a computed branch (MOV PC) takes effect.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < PC_IDX; i++) begin
            if (wr_en_s[i]) begin
                regs_d[i] = bus.PW;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
        if (wr_en_s[PC_IDX]) begin
            regs_d[PC_IDX] = bus.PW;
        end else if (bus.PC_LE) begin
            regs_d[PC_IDX] = bus.PC_in;
        end else begin
            regs_d[PC_IDX] = regs_q[PC_IDX];
        end
    end

    // Register array; reset discards any write or PC load of that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PC_IDX; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
            regs_q[PC_IDX] <= RESET_PC;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Forwarding only ever applies to the general write port, never to PC_LE,
    // and is suppressed while reset is asserted because that write is dropped.
    assign fwd_en_s = BYPASS_ON & bus.LE & ~reset;

    assign rd_sel_s[0] = bus.RA;
    assign rd_sel_s[1] = bus.RB;
    assign rd_sel_s[2] = bus.RD;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd_port
        register_file_mux16 #(
            .WIDTH (WIDTH)
        ) u_mux (
            .sel_i  (rd_sel_s[p]),
            .din_i  (regs_q),
            .dout_o (rd_mux_s[p])
        );

        assign rd_data_s[p] = (fwd_en_s && (rd_sel_s[p] == bus.RW)) ? bus.PW
                                                                     : rd_mux_s[p];
    end

    assign bus.PA     = rd_data_s[0];
    assign bus.PB     = rd_data_s[1];
    assign bus.PD     = rd_data_s[2];

    // PC_out always reflects the stored R15, never the forwarded value.
    assign bus.PC_out = regs_q[PC_IDX];

endmodule : register_file

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam int          W   = 32;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_file_if #(.WIDTH(W)) if0 ();
    register_file_if #(.WIDTH(W)) if1 ();

    // Both DUTs see identical stimulus; dut1 differs only in BYPASS.
    assign if1.LE    = if0.LE;
    assign if1.RW    = if0.RW;
    assign if1.PW    = if0.PW;
    assign if1.RA    = if0.RA;
    assign if1.RB    = if0.RB;
    assign if1.RD    = if0.RD;
    assign if1.PC_LE = if0.PC_LE;
    assign if1.PC_in = if0.PC_in;

    register_file #(.WIDTH(W), .RESET_PC(RPC), .BYPASS(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    register_file #(.WIDTH(W), .RESET_PC(RPC), .BYPASS(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain array of architectural register contents.
    logic [31:0] mdl [16];

    typedef struct {
        logic        le;
        logic [3:0]  rw;
        logic [31:0] pw;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rd;
        logic        pc_le;
        logic [31:0] pc_in;
        logic [31:0] e_pa;
        logic [31:0] e_pb;
        logic [31:0] e_pd;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic le, input logic [3:0] rw, input logic [31:0] pw,
                          input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
                          input logic pc_le, input logic [31:0] pc_in);
        if0.LE    = le;
        if0.RW    = rw;
        if0.PW    = pw;
        if0.RA    = ra;
        if0.RB    = rb;
        if0.RD    = rd;
        if0.PC_LE = pc_le;
        if0.PC_in = pc_in;
    endtask

    // One clock edge; the model applies the architectural update rules.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 15; i++) mdl[i] = 32'h0000_0000;
            mdl[15] = RPC;
        end else begin
            if (if0.PC_LE && !(if0.LE && if0.RW == 4'd15)) mdl[15] = if0.PC_in;
            if (if0.LE) mdl[if0.RW] = if0.PW;
        end
        #1;
    endtask

    function automatic logic [31:0] exp_rd(input logic [3:0] sel, input bit byp);
        if (byp && if0.LE && !reset && sel == if0.RW) return if0.PW;
        return mdl[sel];
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_pa0"}, if0.PA,     exp_rd(if0.RA, 1'b0));
        check({tag, "_pb0"}, if0.PB,     exp_rd(if0.RB, 1'b0));
        check({tag, "_pd0"}, if0.PD,     exp_rd(if0.RD, 1'b0));
        check({tag, "_pc0"}, if0.PC_out, mdl[15]);
        check({tag, "_pa1"}, if1.PA,     exp_rd(if0.RA, 1'b1));
        check({tag, "_pb1"}, if1.PB,     exp_rd(if0.RB, 1'b1));
        check({tag, "_pd1"}, if1.PD,     exp_rd(if0.RD, 1'b1));
        check({tag, "_pc1"}, if1.PC_out, mdl[15]);
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'd1,  32'h1111_1111, 4'd1,  4'd0,  4'd15, 1'b0, 32'h0000_0000,
                   32'h1111_1111, 32'h0000_0000, 32'h0000_0100, 32'h0000_0100};
        tbl[1] = '{1'b1, 4'd15, 32'h0000_2000, 4'd15, 4'd1,  4'd2,  1'b1, 32'h0000_0004,
                   32'h0000_2000, 32'h1111_1111, 32'h0000_0000, 32'h0000_2000};
        tbl[2] = '{1'b0, 4'd15, 32'h0000_0000, 4'd15, 4'd1,  4'd2,  1'b1, 32'h0000_2004,
                   32'h0000_2004, 32'h1111_1111, 32'h0000_0000, 32'h0000_2004};
        tbl[3] = '{1'b1, 4'd3,  32'h1111_1111, 4'd3,  4'd15, 4'd1,  1'b0, 32'h0000_0000,
                   32'h1111_1111, 32'h0000_2004, 32'h1111_1111, 32'h0000_2004};
        tbl[4] = '{1'b1, 4'd3,  32'h2222_2222, 4'd3,  4'd3,  4'd3,  1'b0, 32'h0000_0000,
                   32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 32'h0000_2004};
        tbl[5] = '{1'b1, 4'd5,  32'hDEAD_BEEF, 4'd5,  4'd15, 4'd3,  1'b1, 32'h0000_3000,
                   32'hDEAD_BEEF, 32'h0000_3000, 32'h2222_2222, 32'h0000_3000};
        tbl[6] = '{1'b0, 4'd7,  32'hFFFF_FFFF, 4'd7,  4'd7,  4'd7,  1'b0, 32'h0000_0000,
                   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_3000};

        for (int i = 0; i < 16; i++) mdl[i] = 32'h0000_0000;

        // Reset state
        reset = 1'b1;
        set_in(1'b1, 4'd4, 32'h5555_5555, 4'd0, 4'd15, 4'd4, 1'b1, 32'h7777_7777);
        tick();
        reset = 1'b0;
        set_in(1'b0, 4'd0, 32'h0000_0000, 4'd0, 4'd15, 4'd4, 1'b0, 32'h0000_0000);
        #1;
        check("rst_pa_r0",  if0.PA,     32'h0000_0000);
        check("rst_pb_r15", if0.PB,     32'h0000_0100);
        check("rst_pd_r4",  if0.PD,     32'h0000_0000);
        check("rst_pc_out", if0.PC_out, 32'h0000_0100);
        check_model("rst");

        // Table-driven vectors, checked after the edge
        for (int v = 0; v < 7; v++) begin
            set_in(tbl[v].le, tbl[v].rw, tbl[v].pw, tbl[v].ra, tbl[v].rb, tbl[v].rd,
                   tbl[v].pc_le, tbl[v].pc_in);
            tick();
            check($sformatf("tbl%0d_pa", v), if0.PA,     tbl[v].e_pa);
            check($sformatf("tbl%0d_pb", v), if0.PB,     tbl[v].e_pb);
            check($sformatf("tbl%0d_pd", v), if0.PD,     tbl[v].e_pd);
            check($sformatf("tbl%0d_pc", v), if0.PC_out, tbl[v].e_pc);
            check_model($sformatf("tbl%0d", v));
        end

        // Read-during-write on R3
        set_in(1'b1, 4'd3, 32'h1111_1111, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0000_0000);
        tick();
        set_in(1'b1, 4'd3, 32'h2222_2222, 4'd3, 4'd0, 4'd0, 1'b0, 32'h0000_0000);
        #1;
        check("rdw_pre_nobyp", if0.PA, 32'h1111_1111);
        check("rdw_pre_byp",   if1.PA, 32'h2222_2222);
        tick();
        if0.LE = 1'b0;
        #1;
        check("rdw_post_nobyp", if0.PA, 32'h2222_2222);
        check("rdw_post_byp",   if1.PA, 32'h2222_2222);

        // Reset mid-operation discards the write and the PC load
        set_in(1'b1, 4'd5, 32'hDEAD_BEEF, 4'd5, 4'd5, 4'd15, 1'b0, 32'h0000_0000);
        tick();
        reset = 1'b1;
        set_in(1'b1, 4'd5, 32'h1234_5678, 4'd5, 4'd5, 4'd15, 1'b1, 32'h0000_5555);
        #1;
        check("rstmid_pre_byp", if1.PA, 32'hDEAD_BEEF);
        tick();
        reset = 1'b0;
        set_in(1'b0, 4'd0, 32'h0000_0000, 4'd5, 4'd5, 4'd15, 1'b0, 32'h0000_0000);
        #1;
        check("rstmid_r5",  if0.PA,     32'h0000_0000);
        check("rstmid_pd",  if0.PD,     32'h0000_0100);
        check("rstmid_pc0", if0.PC_out, 32'h0000_0100);
        check("rstmid_pc1", if1.PC_out, 32'h0000_0100);

        // LE gating over three edges
        set_in(1'b0, 4'd7, 32'hFFFF_FFFF, 4'd7, 4'd7, 4'd7, 1'b0, 32'h0000_0000);
        repeat (3) tick();
        check("gate_pa",    if0.PA, 32'h0000_0000);
        check("gate_pb_pa", if0.PB, if0.PA);
        check("gate_pd_pa", if0.PD, if0.PA);
        check("gate_pa1",   if1.PA, 32'h0000_0000);

        // Write all of R0-R14, then sweep every port
        for (int n = 0; n < 15; n++) begin
            set_in(1'b1, 4'(n), 32'hA000_0000 + 32'(n), 4'd0, 4'd0, 4'd0, 1'b0, 32'h0000_0000);
            tick();
        end
        if0.LE = 1'b0;
        for (int n = 0; n < 15; n++) begin
            if0.RA = 4'(n);
            if0.RB = 4'(14 - n);
            if0.RD = 4'(n);
            #1;
            check($sformatf("all_pa_r%0d", n), if0.PA, 32'hA000_0000 + 32'(n));
            check($sformatf("all_pb_r%0d", 14 - n), if0.PB, 32'hA000_0000 + 32'(14 - n));
            check($sformatf("all_pd_r%0d", n), if0.PD, 32'hA000_0000 + 32'(n));
        end
        check("all_pc_kept", if0.PC_out, 32'h0000_0100);

        // Randomized traffic against the model, sampled before each edge
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 31) == 0);
            set_in(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom());
            if (c % 8 == 0) if0.RA = if0.RW;
            #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end
        reset = 1'b0;
        if0.LE = 1'b0;
        #1;
        check_model("rnd_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file
